// File: rtl/note_arbiter.sv
// note_arbiter: debounced 7-key keyboard, last-pressed priority, square-wave tone out.
// Define NOTE_ARBITER_SUSTAIN_EN to add the HOLD sustain phase after the last release.
module note_arbiter #(
  parameter int INPUT    = 50000000,
  parameter int DEBOUNCE = 1000000,
  parameter int SUSTAIN  = 12500000,
  parameter int WIDTH    = $clog2(INPUT/131/2-1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       key,
  input  logic             p1,
  input  logic             p2,
  output logic [WIDTH-1:0] tone,
  output logic [2:0]       note,
  output logic [1:0]       octave,
  output logic             gate,
  output logic             speaker
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
`ifdef NOTE_ARBITER_SUSTAIN_EN
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RELEASED = HOLD;
  localparam int SW = (SUSTAIN > 1) ? $clog2(SUSTAIN) : 1;
`else
  localparam logic [1:0] RELEASED = IDLE;
`endif

  if (DEBOUNCE < 1 || SUSTAIN < 1 || WIDTH < 1) begin : g_bad_param
    $error("note_arbiter: DEBOUNCE, SUSTAIN and WIDTH must be positive");
  end

  logic [8:0]       raw;
  logic [8:0]       sync1;
  logic [8:0]       sync2;
  logic [8:0]       deb;
  logic [DW-1:0]    dcnt [9];
  logic [6:0]       deb_q;
  logic [6:0]       rise;
  logic [6:0]       held;
  logic [1:0]       oct_d;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [2:0]       note_n;
  logic [1:0]       oct_n;
  logic [WIDTH-1:0] tone_n;
  logic [WIDTH-1:0] tone_act;
  logic [WIDTH-1:0] cnt;
  logic             sus_done;

  assign raw  = {p2, p1, key};
  assign held = deb[6:0];
  assign rise = deb[6:0] & ~deb_q;
  assign gate = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 9; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb[6:0];
      for (int i = 0; i < 9; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE-1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      deb[7] & deb[8]: oct_d = 2'd2;
      deb[7] ^ deb[8]: oct_d = 2'd1;
      default:         oct_d = 2'd0;
    endcase
  end

  function automatic logic [2:0] hi_idx(input logic [6:0] v);
    hi_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) hi_idx = 3'(i);
    end
  endfunction

  // Half-period counts, folded to constants at elaboration.
  function automatic logic [WIDTH-1:0] lut(
    input logic [1:0] o,
    input logic [2:0] n
  );
    case ({o, n})
      5'd0:    lut = WIDTH'(INPUT/131/2-1);
      5'd1:    lut = WIDTH'(INPUT/147/2-1);
      5'd2:    lut = WIDTH'(INPUT/165/2-1);
      5'd3:    lut = WIDTH'(INPUT/175/2-1);
      5'd4:    lut = WIDTH'(INPUT/196/2-1);
      5'd5:    lut = WIDTH'(INPUT/220/2-1);
      5'd6:    lut = WIDTH'(INPUT/247/2-1);
      5'd8:    lut = WIDTH'(INPUT/262/2-1);
      5'd9:    lut = WIDTH'(INPUT/294/2-1);
      5'd10:   lut = WIDTH'(INPUT/330/2-1);
      5'd11:   lut = WIDTH'(INPUT/349/2-1);
      5'd12:   lut = WIDTH'(INPUT/392/2-1);
      5'd13:   lut = WIDTH'(INPUT/440/2-1);
      5'd14:   lut = WIDTH'(INPUT/494/2-1);
      5'd16:   lut = WIDTH'(INPUT/523/2-1);
      5'd17:   lut = WIDTH'(INPUT/587/2-1);
      5'd18:   lut = WIDTH'(INPUT/659/2-1);
      5'd19:   lut = WIDTH'(INPUT/698/2-1);
      5'd20:   lut = WIDTH'(INPUT/784/2-1);
      5'd21:   lut = WIDTH'(INPUT/880/2-1);
      5'd22:   lut = WIDTH'(INPUT/988/2-1);
      default: lut = '0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    note_n  = note;
    oct_n   = octave;
    case (state)
      IDLE: begin
        if (|rise) begin
          state_n = PLAY;
          note_n  = hi_idx(rise);
          oct_n   = oct_d;
        end
      end
      PLAY: begin
        oct_n = oct_d;
        if (|rise) begin
          note_n = hi_idx(rise);
        end else if (held == '0) begin
          state_n = RELEASED;
        end else if (!held[note]) begin
          note_n = hi_idx(held);
        end
      end
`ifdef NOTE_ARBITER_SUSTAIN_EN
      HOLD: begin
        oct_n = oct_d;
        if (|rise) begin
          state_n = PLAY;
          note_n  = hi_idx(rise);
        end else if (sus_done) begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign tone_n = lut(oct_n, note_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      note   <= '0;
      octave <= '0;
      tone   <= '0;
    end else begin
      state <= state_n;
      // Keep the last note/tone visible once the voice has ended.
      if (state_n != IDLE) begin
        note   <= note_n;
        octave <= oct_n;
        tone   <= tone_n;
      end
    end
  end

`ifdef NOTE_ARBITER_SUSTAIN_EN
  logic [SW-1:0] sus_cnt;

  assign sus_done = (sus_cnt == SW'(SUSTAIN-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sus_cnt <= '0;
    end else if (state == HOLD && state_n == HOLD) begin
      sus_cnt <= sus_cnt + SW'(1);
    end else begin
      sus_cnt <= '0;
    end
  end
`else
  assign sus_done = 1'b0;
`endif

  // A new period length only takes effect at a toggle, so retunes never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tone_act <= '0;
      speaker  <= 1'b0;
    end else if (state_n == IDLE) begin
      cnt     <= '0;
      speaker <= 1'b0;
    end else if (state == IDLE) begin
      cnt      <= '0;
      speaker  <= 1'b0;
      tone_act <= tone_n;
    end else if (cnt == tone_act) begin
      cnt      <= '0;
      speaker  <= ~speaker;
      tone_act <= tone;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_note_arbiter.sv
// tb_note_arbiter: vector table plus hand sequences, scoreboard of expected notes.
// Honors NOTE_ARBITER_SUSTAIN_EN for the release timing.
module tb_note_arbiter;

  localparam int DEB = 4;
  localparam int SUS = 20;
  localparam int W   = 18;
`ifdef NOTE_ARBITER_SUSTAIN_EN
  localparam int REL = DEB + 3 + SUS;
`else
  localparam int REL = DEB + 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   key;
  logic         p1;
  logic         p2;
  logic [W-1:0] tone;
  logic [2:0]   note;
  logic [1:0]   octave;
  logic         gate;
  logic         speaker;

  typedef struct packed {
    logic [2:0]   note;
    logic [1:0]   oct;
    logic [W-1:0] tone;
  } exp_t;

  typedef struct {
    logic [6:0]   key;
    logic         p1;
    logic         p2;
    logic [2:0]   note;
    logic [1:0]   oct;
    logic [W-1:0] tone;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  note_arbiter #(
    .INPUT   (50000000),
    .DEBOUNCE(DEB),
    .SUSTAIN (SUS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .p1     (p1),
    .p2     (p2),
    .tone   (tone),
    .note   (note),
    .octave (octave),
    .gate   (gate),
    .speaker(speaker)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sbq.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sbq.pop_front();
      chk({tag, " note"}, 32'(note), 32'(x.note));
      chk({tag, " octave"}, 32'(octave), 32'(x.oct));
      chk({tag, " tone"}, 32'(tone), 32'(x.tone));
    end
  endtask

  task automatic press(input logic [6:0] k, input logic a, input logic b,
                       input logic [2:0] en, input logic [1:0] eo,
                       input logic [W-1:0] et, input bit from_idle,
                       input logic [2:0] prev, input string tag);
    exp_t x;
    key = k;
    p1  = a;
    p2  = b;
    x   = {en, eo, et};
    sbq.push_back(x);
    for (int e = 1; e <= DEB + 3; e++) begin
      tick();
      if (from_idle && e == DEB + 2) chk({tag, " gate early"}, 32'(gate), 0);
      if (!from_idle) begin
        chk({tag, " gate held"}, 32'(gate), 1);
        if (e == DEB + 2) chk({tag, " note early"}, 32'(note), 32'(prev));
      end
    end
    if (from_idle) chk({tag, " gate on"}, 32'(gate), 1);
    pop_check(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    key = '0;
    p1  = 1'b0;
    p2  = 1'b0;
    n   = 0;
    while (gate !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (gate !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: gate stuck high got %0d expected 0", tag, gate);
    end
    repeat (DEB + 4) tick();
  endtask

  initial begin
    int n;
    vt[0] = '{7'b0100000, 1'b0, 1'b0, 3'd5, 2'd0, 18'd113635};
    vt[1] = '{7'b0100000, 1'b1, 1'b0, 3'd5, 2'd1, 18'd56817};
    vt[2] = '{7'b1000001, 1'b1, 1'b1, 3'd6, 2'd2, 18'd25302};
    vt[3] = '{7'b0000001, 1'b0, 1'b1, 3'd0, 2'd1, 18'd95418};
    vt[4] = '{7'b0001000, 1'b0, 1'b0, 3'd3, 2'd0, 18'd142856};
    vt[5] = '{7'b0000110, 1'b1, 1'b1, 3'd2, 2'd2, 18'd37935};

    rst = 1'b1;
    key = '0;
    p1  = 1'b0;
    p2  = 1'b0;
    repeat (3) tick();
    chk("reset gate", 32'(gate), 0);
    chk("reset speaker", 32'(speaker), 0);
    chk("reset tone", 32'(tone), 0);
    chk("reset note", 32'(note), 0);
    chk("reset octave", 32'(octave), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle gate", 32'(gate), 0);
    chk("idle tone", 32'(tone), 0);

    for (int i = 0; i < 6; i++) begin
      press(vt[i].key, vt[i].p1, vt[i].p2, vt[i].note, vt[i].oct,
            vt[i].tone, 1'b1, 3'd0, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d idle", i));
    end

    press(7'b0000001, 1'b0, 1'b0, 3'd0, 2'd0, 18'd190838, 1'b1, 3'd0, "seqA c");
    press(7'b0001001, 1'b0, 1'b0, 3'd3, 2'd0, 18'd142856, 1'b0, 3'd0, "seqA f");
    press(7'b0000001, 1'b0, 1'b0, 3'd0, 2'd0, 18'd190838, 1'b0, 3'd3, "seqA back");
    press(7'b0000001, 1'b1, 1'b0, 3'd0, 2'd1, 18'd95418, 1'b0, 3'd0, "retune");

    key = '0;
    for (int e = 1; e <= REL; e++) begin
      tick();
      chk($sformatf("release gate e%0d", e), 32'(gate), (e < REL) ? 1 : 0);
    end
    chk("release speaker", 32'(speaker), 0);
    chk("release note kept", 32'(note), 0);
    wait_idle("release idle");

    press(7'b1000000, 1'b1, 1'b1, 3'd6, 2'd2, 18'd25302, 1'b1, 3'd0, "seqC");
    n = 0;
    while (speaker !== 1'b1 && n < 30000) begin
      tick();
      n++;
    end
    chk("half period", 32'(n), 25303);

    #2 rst = 1'b1;
    #1;
    chk("async rst speaker", 32'(speaker), 0);
    chk("async rst gate", 32'(gate), 0);
    chk("async rst tone", 32'(tone), 0);
    chk("async rst note", 32'(note), 0);
    chk("async rst octave", 32'(octave), 0);
    key = '0;
    p1  = 1'b0;
    p2  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      chk("post rst gate", 32'(gate), 0);
      chk("post rst speaker", 32'(speaker), 0);
    end
    press(7'b0100000, 1'b0, 1'b0, 3'd5, 2'd0, 18'd113635, 1'b1, 3'd0, "fresh");
    chk("scoreboard drained", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_arbiter.md
NOTE_ARBITER -- requirements
Module: note_arbiter

Interface
REQ-001 SHALL have parameter INPUT, default 50000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE, default 1000000, meaning the number of consecutive stable cycles required to accept an input change.
REQ-003 SHALL have parameter SUSTAIN, default 12500000, meaning the number of HOLD cycles after the last key is released.
REQ-004 SHALL have parameter WIDTH, default $clog2(INPUT/131/2-1), meaning the tone and counter width (18 at the default INPUT).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port key, input, 7, raw key buttons, bit0=c, bit1=d, bit2=e, bit3=f, bit4=g, bit5=a, bit6=b.
REQ-008 SHALL have ports p1 and p2, input, 1 each, raw octave buttons.
REQ-009 SHALL have port tone, output, WIDTH, the registered half-period count of the selected note.
REQ-010 SHALL have port note, output, 3, the active key index 0..6.
REQ-011 SHALL have port octave, output, 2, the active octave 0..2.
REQ-012 SHALL have port gate, output, 1, high while in PLAY or HOLD.
REQ-013 SHALL have port speaker, output, 1, the square-wave audio output.

Function
REQ-014 Every key, p1 and p2 input SHALL pass through a 2-flop synchronizer followed by a per-input debouncer; the debounced value changes only after DEBOUNCE consecutive cycles of differing synchronized value.
REQ-015 Octave SHALL be decoded from debounced p1/p2: neither pressed = 0; exactly one pressed = 1; both pressed = 2.
REQ-016 The tone table SHALL be INPUT/f/2-1 with integer division, with f given per octave in c..b order:
- octave 0: 131 147 165 175 196 220 247
- octave 1: 262 294 330 349 392 440 494
- octave 2: 523 587 659 698 784 880 988
REQ-017 State machine SHALL have states IDLE, PLAY and HOLD.
- IDLE->PLAY on any debounced key rising edge.
- PLAY->HOLD when no debounced key is held.
- HOLD->PLAY on any key rising edge.
- HOLD->IDLE after SUSTAIN cycles.
REQ-018 Priority SHALL be last-pressed wins: a debounced rising edge makes that key the active note; on simultaneous rising edges the highest index (b) wins.
REQ-019 When the active key is released while others are held, note SHALL fall back to the highest-index held key, without leaving PLAY.
REQ-020 A debounced octave change in PLAY or HOLD SHALL retune tone without retrigger.
REQ-021 note, octave and tone SHALL update on the cycle after the debounced event; pin-to-gate latency SHALL be exactly DEBOUNCE+3 edges.
REQ-022 The half-period counter SHALL count 0..tone_active, toggle speaker at terminal count and return to 0.
REQ-023 tone_active SHALL load from tone only at a toggle or on IDLE->PLAY, keeping the waveform phase-continuous.
REQ-024 In IDLE, the counter SHALL be held at 0 and speaker at 0; on HOLD->IDLE, speaker SHALL go 0 immediately.
REQ-025 In HOLD, note, octave and tone SHALL keep their last values.

Reset
REQ-026 While rst is high, the state SHALL be IDLE and all of the following SHALL be 0: tone, note, octave, gate, speaker, the counters, the synchronizers and the debounced values.
REQ-027 Assertion of rst mid-note SHALL silence speaker asynchronously; after release, no note SHALL play until a fresh debounced rising edge.

Configuration
REQ-028 Macro NOTE_ARBITER_SUSTAIN_EN SHALL control HOLD.
- Defined: HOLD and the SUSTAIN counter exist as in REQ-017.
- Undefined: PLAY->IDLE occurs directly when no key is held; SUSTAIN is ignored.

Verification (DEBOUNCE=4, SUSTAIN=20, INPUT=50000000)
REQ-029 Hold key[5] with p1=p2=0 -> gate=1 at edge 7, note=5, octave=0, tone=113635.
REQ-030 Hold key[5] with p1=1, p2=0 -> tone=56817, and speaker period is 2*56818 cycles.
REQ-031 Rise key[0] and key[6] in the same cycle with p1=p2=1 -> note=6, tone=25302.
REQ-032 Hold key[0], then press key[3], then release key[3] -> note goes 0, then 3, then 0; gate stays 1.
REQ-033 Release all keys -> gate stays 1 for 20 cycles, then 0 and speaker=0 (without macro: immediately).
REQ-034 Assert rst mid-tone -> all outputs 0 the same cycle; after release, outputs stay 0 until a new press.
